// File: rtl/sdram_ahb_stream_writer_pkg.sv
// Shared AHB-Lite encodings and writer FSM states for the SID stream-to-SDRAM path.
package sid_sdram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam int BURST_LEN = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } wr_state_e;

endpackage

// File: rtl/sdram_ahb_stream_writer_if.sv
// AHB-Lite write-master bundle between the stream writer and the SDRAM controller slave port.
interface sdram_ahb_stream_writer_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP
    );

endinterface

// File: rtl/sdram_ahb_stream_writer_stage.sv
// Four-word staging buffer with fill count; words are read back by beat index during a burst.
module sdram_wr_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        clear,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [2:0]  count
);

    logic [31:0] words [4];

    // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (push) begin
            count <= count + 3'd1;
        end
    end

    // NOTE: the data array is deliberately not reset; count says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            words[count[1:0]] <= push_data;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/sdram_ahb_stream_writer.sv
// AHB-Lite INCR4 writer: stages stream words in groups of four and bursts them into a circular SDRAM buffer.
module sdram_ahb_stream_writer
    import sid_sdram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          BUF_WORDS = 4096,
    parameter int          PTR_W     = $clog2(BUF_WORDS)
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 enable,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    sdram_ahb_stream_writer_if.master ahb,
    output logic [PTR_W-1:0]     wr_ptr,
    output logic                 busy,
    output logic                 err
);

    localparam logic [1:0] FILL  = 2'(ST_FILL);
    localparam logic [1:0] BURST = 2'(ST_BURST);
    localparam logic [1:0] DRAIN = 2'(ST_DRAIN);
    localparam logic [1:0] ERROR = 2'(ST_ERROR);

    logic [1:0]  state;
    logic [1:0]  beat;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  count;
    logic [31:0] stage_word;
    logic [31:0] ptr_byte;
    logic        push;
    logic        clear;
    logic        bus_error;

    // Gated by reset so the combinational ready cannot advertise space while HRESETN is low.
    assign s_ready   = HRESETN && (state == FILL) && (count < 3'd4);
    assign push      = s_valid && s_ready;
    assign bus_error = (ahb.HRESP == HRESP_ERROR) && !ahb.HREADY;
    assign clear     = ((state == DRAIN) && ahb.HREADY) || ((state == ERROR) && !enable);
    assign ptr_byte  = 32'(wr_ptr) << 2;
    assign busy      = (state == BURST) || (state == DRAIN);

    sdram_wr_stage u_stage (
        .clk       (HCLK),
        .rst_n     (HRESETN),
        .push      (push),
        .push_data (s_data),
        .clear     (clear),
        .rd_idx    (beat),
        .rd_data   (stage_word),
        .count     (count)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state  <= FILL;
            beat   <= 2'd0;
            htrans <= HTRANS_IDLE;
            haddr  <= BASE_ADDR;
            hwrite <= 1'b0;
            hwdata <= 32'h0;
            wr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if ((count == 3'd4) && enable) begin
                        state  <= BURST;
                        beat   <= 2'd0;
                        htrans <= HTRANS_NONSEQ;
                        haddr  <= BASE_ADDR + ptr_byte;
                        hwrite <= 1'b1;
                    end
                end
                BURST: begin
                    if (bus_error) begin
                        state  <= ERROR;
                        htrans <= HTRANS_IDLE;
                        hwrite <= 1'b0;
                        err    <= 1'b1;
                    end else if (ahb.HREADY) begin
                        // Data phase trails the address phase by one accepted beat.
                        hwdata <= stage_word;
                        if (beat == 2'(BURST_LEN - 1)) begin
                            state  <= DRAIN;
                            htrans <= HTRANS_IDLE;
                            hwrite <= 1'b0;
                        end else begin
                            beat   <= beat + 2'd1;
                            htrans <= HTRANS_SEQ;
                            haddr  <= haddr + 32'd4;
                        end
                    end
                end
                DRAIN: begin
                    if (bus_error) begin
                        state  <= ERROR;
                        err    <= 1'b1;
                    end else if (ahb.HREADY) begin
                        state  <= FILL;
                        wr_ptr <= wr_ptr + PTR_W'(BURST_LEN);
                    end
                end
                ERROR: begin
                    if (!enable) begin
                        state <= FILL;
                        err   <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign ahb.HADDR  = haddr;
    assign ahb.HTRANS = htrans;
    assign ahb.HWRITE = hwrite;
    assign ahb.HWDATA = hwdata;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HBURST = HBURST_INCR4;

endmodule

// File: tb/tb_sdram_ahb_stream_writer.sv
// Self-checking bench: bus monitor and word-level scoreboard against a queue model of the circular buffer.
module tb_sdram_ahb_stream_writer;

    localparam logic [31:0] BASE = 32'h2000_0400;
    localparam int          BUF  = 8;
    localparam int          PW   = $clog2(BUF);

    logic          HCLK    = 1'b0;
    logic          HRESETN = 1'b0;
    logic          enable  = 1'b0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data  = 32'h0;
    logic          s_ready;
    logic [PW-1:0] wr_ptr;
    logic          busy;
    logic          err;

    sdram_ahb_stream_writer_if bus ();

    sdram_ahb_stream_writer #(.BASE_ADDR(BASE), .BUF_WORDS(BUF)) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .enable  (enable),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .ahb     (bus),
        .wr_ptr  (wr_ptr),
        .busy    (busy),
        .err     (err)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words accepted so far, buffer pointer, and expected {addr, data} beats.
    int          m_ptr = 0;
    logic [31:0] m_words [$];
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];

    // Passive bus monitor: pairs each accepted write address with the data of its data phase.
    logic        mon_pend = 1'b0;
    logic [31:0] mon_addr = 32'h0;

    always @(negedge HCLK) begin
        if (!HRESETN || bus.HRESP == 2'b01) begin
            mon_pend <= 1'b0;
        end else if (bus.HREADY) begin
            if (mon_pend) obs_q.push_back({mon_addr, bus.HWDATA});
            mon_pend <= bus.HTRANS[1] && bus.HWRITE;
            mon_addr <= bus.HADDR;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic model_push(input logic [31:0] w);
        m_words.push_back(w);
        if (m_words.size() == 4) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back({BASE + 32'(((m_ptr + i) % BUF) * 4), m_words[i]});
            m_ptr = (m_ptr + 4) % BUF;
            m_words.delete();
        end
    endtask

    task automatic flush();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        int t = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: s_ready stayed %b for %0d cycles, required 1", s_ready, t);
        end else begin
            model_push(w);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((obs_q.size() < exp_q.size() || busy) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: saw %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [75+PW:0] got_v;
        logic [75+PW:0] exp_v;
        HRESETN    = 1'b0;
        enable     = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        repeat (3) tick();
        got_v = {s_ready, bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.HSIZE, bus.HBURST, wr_ptr, err, busy};
        exp_v = {1'b0, 2'b00, BASE, 1'b0, 32'h0, 3'b010, 3'b011, PW'(0), 1'b0, 1'b0};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required %h", got_v, exp_v);
        end
        HRESETN = 1'b1;
        tick();
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", s_ready);
        end
        m_ptr = 0;
        flush();
    endtask

    task automatic test_single_burst();
        logic [31:0] w [4]      = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        logic [1:0]  exp_tr [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        int start = m_ptr;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push_word(w[i]);
        n_cmp++;
        if (s_ready !== 1'b0 || bus.HTRANS !== 2'b00) begin
            n_bad++;
            $display("FAIL single_full: s_ready %b htrans %b, required 0 and 00", s_ready, bus.HTRANS);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.HTRANS !== exp_tr[k] || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL single_htrans%0d: got %b busy %b, required %b busy 1", k, bus.HTRANS, busy, exp_tr[k]);
            end
            if (k < 4) begin
                n_cmp++;
                if (bus.HADDR !== BASE + 32'(((start + k) % BUF) * 4)) begin
                    n_bad++;
                    $display("FAIL single_haddr%0d: got %h required %h", k, bus.HADDR, BASE + 32'(((start + k) % BUF) * 4));
                end
            end
            if (k > 0) begin
                n_cmp++;
                if (bus.HWDATA !== w[k-1]) begin
                    n_bad++;
                    $display("FAIL single_hwdata%0d: got %h required %h", k, bus.HWDATA, w[k-1]);
                end
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || wr_ptr !== PW'(m_ptr)) begin
            n_bad++;
            $display("FAIL single_done: busy %b wr_ptr %0d, required 0 and %0d", busy, wr_ptr, m_ptr);
        end
        flush();
    endtask

    task automatic test_wait_states();
        logic [31:0] w [4];
        logic [31:0] a2;
        int start = m_ptr;
        int cyc   = 0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        a2 = BASE + 32'(((start + 2) % BUF) * 4);
        for (int i = 0; i < 4; i++) push_word(w[i]);
        tick();
        while (busy && cyc < 30) begin
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++;
                if ({bus.HTRANS, bus.HADDR, bus.HWDATA} !== {2'b11, a2, w[1]}) begin
                    n_bad++;
                    $display("FAIL wait_hold%0d: got %b %h %h required 11 %h %h", cyc, bus.HTRANS, bus.HADDR, bus.HWDATA, a2, w[1]);
                end
            end
            bus.HREADY = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        bus.HREADY = 1'b1;
        n_cmp++;
        if (cyc != 7) begin
            n_bad++;
            $display("FAIL wait_latency: got %0d cycles required 7", cyc);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL wait_beats: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL wait_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        flush();
    endtask

    task automatic test_wrap();
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) push_word($urandom);
            wait_drain();
            n_cmp++;
            if (wr_ptr !== PW'(m_ptr)) begin
                n_bad++;
                $display("FAIL wrap_ptr%0d: got %0d required %0d", g, wr_ptr, m_ptr);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL wrap_beats: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL wrap_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        flush();
    endtask

    task automatic test_error();
        int start = m_ptr;
        for (int i = 0; i < 4; i++) push_word($urandom);
        repeat (3) tick();
        bus.HRESP  = 2'b01;
        bus.HREADY = 1'b0;
        tick();
        n_cmp++;
        if ({bus.HTRANS, err, s_ready, busy, wr_ptr} !== {2'b00, 1'b1, 1'b0, 1'b0, PW'(start)}) begin
            n_bad++;
            $display("FAIL error_entry: htrans %b err %b s_ready %b busy %b wr_ptr %0d, required 00 1 0 0 %0d",
                     bus.HTRANS, err, s_ready, busy, wr_ptr, start);
        end
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 2'b00;
        repeat (3) tick();
        n_cmp++;
        if ({bus.HTRANS, err, s_ready} !== {2'b00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL error_hold: htrans %b err %b s_ready %b, required 00 1 0", bus.HTRANS, err, s_ready);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL error_clear: err %b s_ready %b, required 0 1", err, s_ready);
        end
        enable = 1'b1;
        m_ptr  = start;
        m_words.delete();
        flush();
    endtask

    task automatic test_enable();
        int start = m_ptr;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_word($urandom);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({bus.HTRANS, s_ready, busy} !== {2'b00, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL enable_hold%0d: htrans %b s_ready %b busy %b, required 00 0 0", c, bus.HTRANS, s_ready, busy);
            end
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== BASE + 32'(start * 4)) begin
            n_bad++;
            $display("FAIL enable_start: htrans %b haddr %h, required 10 %h", bus.HTRANS, bus.HADDR, BASE + 32'(start * 4));
        end
        enable = 1'b0;
        wait_drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || wr_ptr !== PW'(m_ptr)) begin
            n_bad++;
            $display("FAIL enable_drop: beats %0d wr_ptr %0d, required %0d and %0d", obs_q.size(), wr_ptr, exp_q.size(), m_ptr);
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL enable_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        enable = 1'b1;
        flush();
    endtask

    task automatic test_random();
        int pushed = 0;
        int cyc    = 0;
        while ((pushed < 20 || obs_q.size() < exp_q.size() || busy) && cyc < 3000) begin
            bus.HREADY = ($urandom_range(0, 3) != 0);
            if (pushed < 20) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
            end else begin
                s_valid = 1'b0;
            end
            if (s_valid && s_ready) begin
                model_push(s_data);
                pushed++;
            end
            tick();
            cyc++;
        end
        s_valid    = 1'b0;
        bus.HREADY = 1'b1;
        n_cmp++;
        if (cyc >= 3000 || obs_q.size() != exp_q.size() || wr_ptr !== PW'(m_ptr)) begin
            n_bad++;
            $display("FAIL random_run: cycles %0d beats %0d/%0d wr_ptr %0d, required beats equal and wr_ptr %0d",
                     cyc, obs_q.size(), exp_q.size(), wr_ptr, m_ptr);
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL random_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid_burst();
        logic [75+PW:0] got_v;
        logic [75+PW:0] exp_v;
        int start;
        if (m_ptr == 0) begin
            for (int i = 0; i < 4; i++) push_word($urandom);
            wait_drain();
            flush();
        end
        start = m_ptr;
        for (int i = 0; i < 4; i++) push_word($urandom);
        repeat (3) tick();
        n_cmp++;
        if (bus.HTRANS !== 2'b11 || bus.HADDR !== BASE + 32'(((start + 2) % BUF) * 4)) begin
            n_bad++;
            $display("FAIL midreset_beat2: htrans %b haddr %h, required 11 %h", bus.HTRANS, bus.HADDR, BASE + 32'(((start + 2) % BUF) * 4));
        end
        HRESETN = 1'b0;
        #1;
        got_v = {s_ready, bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.HSIZE, bus.HBURST, wr_ptr, err, busy};
        exp_v = {1'b0, 2'b00, BASE, 1'b0, 32'h0, 3'b010, 3'b011, PW'(0), 1'b0, 1'b0};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL midreset_async: got %h required %h", got_v, exp_v);
        end
        tick();
        HRESETN = 1'b1;
        m_ptr   = 0;
        m_words.delete();
        flush();
        tick();
        for (int i = 0; i < 4; i++) push_word($urandom);
        tick();
        n_cmp++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== BASE) begin
            n_bad++;
            $display("FAIL midreset_restart: htrans %b haddr %h, required 10 %h", bus.HTRANS, bus.HADDR, BASE);
        end
        wait_drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || wr_ptr !== PW'(m_ptr)) begin
            n_bad++;
            $display("FAIL midreset_done: beats %0d wr_ptr %0d, required %0d and %0d", obs_q.size(), wr_ptr, exp_q.size(), m_ptr);
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL midreset_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        flush();
    endtask

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        test_reset();
        test_single_burst();
        test_wait_states();
        test_wrap();
        test_error();
        test_enable();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
